rstation_dispatch: RTL

RSTATION_DISPATCH -- requirements
Module: rstation_dispatch

---
 rtl/rstation_dispatch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rstation_dispatch.sv
// rstation_dispatch: reservation station with CDB wakeup, oldest-first select and a registered dispatch stage
module rstation_dispatch #(
   parameter int DEPTH = 4,
   parameter int DW = 8,
   parameter int TW = 3
) (
   input  logic                     clk2,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alloc_valid,
   output logic                     alloc_ready,
   input  logic [3:0]               alloc_func,
   input  logic                     alloc_j_rdy,
   input  logic                     alloc_k_rdy,
   input  logic [DW-1:0]            alloc_vj,
   input  logic [DW-1:0]            alloc_vk,
   input  logic [TW-1:0]            alloc_qj,
   input  logic [TW-1:0]            alloc_qk,
   input  logic [TW-1:0]            alloc_rob,
   input  logic                     cdb_valid,
   input  logic [TW-1:0]            cdb_rob,
   input  logic [DW-1:0]            cdb_data,
   output logic                     disp_valid,
   input  logic                     disp_ready,
   output logic [3:0]               disp_func,
   output logic [DW-1:0]            disp_vj,
   output logic [DW-1:0]            disp_vk,
   output logic [TW-1:0]            disp_rob,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   logic [DEPTH-1:0] busy, j_rdy, k_rdy;
   logic [3:0]       func_q [DEPTH];
   logic [DW-1:0]    vj_q   [DEPTH];
   logic [DW-1:0]    vk_q   [DEPTH];
   logic [TW-1:0]    qj_q   [DEPTH];
   logic [TW-1:0]    qk_q   [DEPTH];
   logic [TW-1:0]    rob_q  [DEPTH];
   logic [CW-1:0]    age    [DEPTH];
   logic [IW-1:0]    free_idx, sel_idx;
   logic [CW-1:0]    sel_age;
   logic             any_elig, fire, load, new_jr, new_kr;
   logic [DW-1:0]    new_vj, new_vk;

   assign alloc_ready = count < CW'(DEPTH);
   assign fire = alloc_valid && alloc_ready;
   assign load = (!disp_valid || disp_ready) && any_elig;
   assign new_jr = alloc_j_rdy || (cdb_valid && cdb_rob == alloc_qj);
   assign new_kr = alloc_k_rdy || (cdb_valid && cdb_rob == alloc_qk);
   assign new_vj = alloc_j_rdy ? alloc_vj : cdb_data;
   assign new_vk = alloc_k_rdy ? alloc_vk : cdb_data;

   // lowest free slot for allocation; smallest age stamp among ready entries for dispatch
   always_comb begin
      free_idx = '0;
      sel_idx = '0;
      sel_age = '0;
      any_elig = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!busy[i]) free_idx = IW'(i);
      for (int i = 0; i < DEPTH; i++)
         if (busy[i] && j_rdy[i] && k_rdy[i] && (!any_elig || age[i] < sel_age)) begin
            sel_idx = IW'(i);
            sel_age = age[i];
            any_elig = 1'b1;
         end
   end

   // entry array: allocation with bypass, CDB capture, and age ranks compacted on dispatch
   always_ff @(posedge clk2) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst || flush) begin
            busy[i] <= 1'b0;
            age[i] <= '0;
         end else if (fire && free_idx == IW'(i)) begin
            busy[i] <= 1'b1;
            func_q[i] <= alloc_func;
            j_rdy[i] <= new_jr;
            k_rdy[i] <= new_kr;
            vj_q[i] <= new_vj;
            vk_q[i] <= new_vk;
            qj_q[i] <= alloc_qj;
            qk_q[i] <= alloc_qk;
            rob_q[i] <= alloc_rob;
            age[i] <= count - CW'(load);
         end else begin
            if (load && sel_idx == IW'(i)) busy[i] <= 1'b0;
            if (load && busy[i] && age[i] > sel_age) age[i] <= age[i] - CW'(1);
            if (cdb_valid && !j_rdy[i] && qj_q[i] == cdb_rob) begin
               vj_q[i] <= cdb_data;
               j_rdy[i] <= 1'b1;
            end
            if (cdb_valid && !k_rdy[i] && qk_q[i] == cdb_rob) begin
               vk_q[i] <= cdb_data;
               k_rdy[i] <= 1'b1;
            end
         end
      end
   end

   // output register: loads the selected entry when empty or being consumed, holds under backpressure
   always_ff @(posedge clk2) begin
      if (rst) begin
         disp_valid <= 1'b0;
         disp_func <= '0;
         disp_vj <= '0;
         disp_vk <= '0;
         disp_rob <= '0;
      end else if (flush) begin
         disp_valid <= 1'b0;
      end else if (load) begin
         disp_valid <= 1'b1;
         disp_func <= func_q[sel_idx];
         disp_vj <= vj_q[sel_idx];
         disp_vk <= vk_q[sel_idx];
         disp_rob <= rob_q[sel_idx];
      end else if (disp_ready) begin
         disp_valid <= 1'b0;
      end
   end

   // occupancy of the station, excluding the output register
   always_ff @(posedge clk2) begin
      if (rst || flush) count <= '0;
      else count <= count + CW'(fire) - CW'(load);
   end
endmodule
